manchester_frame_decoder: RTL

//   Parametrised Manchester bit-slicer and deserialiser. Consumes single-cycle pos_edge/neg_edge

---
 rtl/manchester_pkg.sv | 23 ++
 rtl/manchester_deserializer.sv | 59 +++++
 rtl/manchester_frame_decoder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/manchester_pkg.sv
// Shared definitions for the Manchester frame decoder: FSM state encoding,
// polarity constants and the blank/window timing derivation.
package manchester_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BLANK  = 2'd1,
        WINDOW = 2'd2
    } state_t;

    localparam int POLARITY_THOMAS = 0;
    localparam int POLARITY_IEEE   = 1;

    // Boundary transitions fall at half a bit; blanking to 3/4 of a bit hides them
    function automatic int blank_cycles(input int bit_cycles);
        return (3 * bit_cycles) / 4;
    endfunction

    function automatic int window_cycles(input int bit_cycles);
        return bit_cycles / 2;
    endfunction

endpackage

// File: rtl/manchester_deserializer.sv
// Packs decoded bits into DATA_W-bit words; MSB_FIRST selects which end the
// first bit of a word lands in. clear discards any partially assembled word.
module manchester_deserializer
    import manchester_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              bit_strobe,
    input  logic              clear,
    output logic [DATA_W-1:0] word_data,
    output logic              word_valid
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_next;
    logic [CNT_W-1:0]  cnt_q;

    always_comb begin
        if (MSB_FIRST != 0) begin
            shift_next    = shift_q << 1;
            shift_next[0] = bit_in;
        end else begin
            shift_next           = shift_q >> 1;
            shift_next[DATA_W-1] = bit_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                shift_q <= '0;
                cnt_q   <= '0;
            end else if (bit_strobe) begin
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    word_data  <= shift_next;
                    word_valid <= 1'b1;
                    shift_q    <= '0;
                    cnt_q      <= '0;
                end else begin
                    shift_q <= shift_next;
                    cnt_q   <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/manchester_frame_decoder.sv
// Manchester bit-slicer: locks on a frame's leading rising edge, decodes mid-bit edges
// into bits and words. Define MANCHESTER_VIOLATION_EN to flag simultaneous pos/neg edges.
module manchester_frame_decoder
    import manchester_pkg::*;
#(
    parameter int BIT_CYCLES = 18,
    parameter int DATA_W     = 8,
    parameter int POLARITY   = 0,
    parameter int MSB_FIRST  = 1,
    parameter int COUNT_W    = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pos_edge,
    input  logic               neg_edge,
    output logic               bit_valid,
    output logic               bit_data,
    output logic               word_valid,
    output logic [DATA_W-1:0]  word_data,
    output logic               frame_start,
    output logic               frame_end,
    output logic [COUNT_W-1:0] bit_count,
    output logic               busy,
    output logic               violation
);

    localparam int   BLANK_CYC = blank_cycles(BIT_CYCLES);
    localparam int   WIN_CYC   = window_cycles(BIT_CYCLES);
    localparam int   TIMER_W   = $clog2(BIT_CYCLES + 1);
    localparam logic POL_BIT   = (POLARITY == POLARITY_IEEE);

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 bit_stb;
    logic                 bit_val;
    logic                 fs_d;
    logic                 fe_d;
    logic                 clr;
    logic [COUNT_W-1:0]   bc_d;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef MANCHESTER_VIOLATION_EN
    logic viol_d;
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_stb = 1'b0;
        bit_val = bit_data;
        fs_d    = 1'b0;
        fe_d    = 1'b0;
        clr     = 1'b0;
        bc_d    = bit_count;
`ifdef MANCHESTER_VIOLATION_EN
        viol_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                timer_d = '0;
                // The leading rising edge only synchronises; it carries no data
                if (pos_edge) begin
                    state_d = BLANK;
                    fs_d    = 1'b1;
                    bc_d    = '0;
                    clr     = 1'b1;
                end
            end
            BLANK: begin
                timer_d = timer_q + 1'b1;
`ifdef MANCHESTER_VIOLATION_EN
                viol_d  = pos_edge && neg_edge;
`endif
                if (timer_q == TIMER_W'(BLANK_CYC - 1)) begin
                    state_d = WINDOW;
                    timer_d = '0;
                end
            end
            WINDOW: begin
                timer_d = timer_q + 1'b1;
`ifdef MANCHESTER_VIOLATION_EN
                if (pos_edge && neg_edge) begin
                    viol_d  = 1'b1;
                    fe_d    = 1'b1;
                    clr     = 1'b1;
                    state_d = IDLE;
                    timer_d = '0;
                end else
`endif
                if (pos_edge || neg_edge) begin
                    bit_stb = 1'b1;
                    bit_val = pos_edge ? POL_BIT : ~POL_BIT;
                    bc_d    = sat_inc(bit_count);
                    state_d = BLANK;
                    timer_d = '0;
                end else if (timer_q == TIMER_W'(WIN_CYC - 1)) begin
                    state_d = IDLE;
                    fe_d    = 1'b1;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_valid   <= 1'b0;
            bit_data    <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            bit_count   <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_valid   <= bit_stb;
            bit_data    <= bit_val;
            frame_start <= fs_d;
            frame_end   <= fe_d;
            bit_count   <= bc_d;
        end
    end

`ifdef MANCHESTER_VIOLATION_EN
    always_ff @(posedge clock) begin
        if (reset) violation <= 1'b0;
        else       violation <= viol_d;
    end
`else
    assign violation = 1'b0;
`endif

    assign busy = (state_q != IDLE);

    manchester_deserializer #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_deser (
        .clock      (clock),
        .reset      (reset),
        .bit_in     (bit_val),
        .bit_strobe (bit_stb),
        .clear      (clr),
        .word_data  (word_data),
        .word_valid (word_valid)
    );

endmodule
